sb_drain_dcache_port: RTL and testbench

Store-side write port of the data cache: the receiving end of the store-buffer drain interface. Each drained store (address, data, byte/word size) is looked up in a direct-mapped write-back line array and merged on a hit. On a miss the port evicts the dirty victim to memory, fills the line, then merges the store. While it is busy it back-pressures the store buffer through `stall_out`, so the buffer keeps re-presenting the same entry.

---
 rtl/sb_drain_dcache_port.sv | 225 ++++++++++++++++++++++
 tb/tb_sb_drain_dcache_port.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_drain_dcache_port.sv
// ---------------------------------------------------------------------------
// sb_drain_dcache_port
//
// Store-side write port of a direct-mapped, write-back data cache. It
// receives stores drained from the store buffer, merges hits directly into
// the line array, and handles misses by writing back a dirty victim and
// then filling the line. While it is busy it holds the store buffer with
// stall_out.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   drain_in           store buffer presents a store this cycle
//   addr_in            store byte address
//   data_in            store data (byte stores use [7:0])
//   is_byte_in         1 = byte store, 0 = word store
//   stall_out          store not accepted this cycle, hold it (combinational)
//   mem_req/mem_we     line request to memory; we=1 write-back, we=0 fill
//   mem_addr           line-aligned request address
//   mem_wdata          victim line for write-back
//   mem_ready          one-cycle completion pulse, only honoured while mem_req
//   mem_rdata          fill data, valid with mem_ready during a fill
//   lk_addr            probe address
//   lk_hit, lk_data    probe result (combinational, pre-write array contents)
// ---------------------------------------------------------------------------
module sb_drain_dcache_port #(
    parameter int NUM_LINES = 4,
    parameter int LINE_BITS = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 drain_in,
    input  logic [31:0]          addr_in,
    input  logic [31:0]          data_in,
    input  logic                 is_byte_in,
    output logic                 stall_out,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [LINE_BITS-1:0] mem_wdata,
    input  logic                 mem_ready,
    input  logic [LINE_BITS-1:0] mem_rdata,
    input  logic [31:0]          lk_addr,
    output logic                 lk_hit,
    output logic [31:0]          lk_data
);

    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_LO = 4 + IDX_W;
    localparam int TAG_W  = 32 - TAG_LO;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_FILL = 2'd2
    } state_e;

    // Merge one store (byte or aligned word) into a line image.
    function automatic logic [LINE_BITS-1:0] merge_store(
        input logic [LINE_BITS-1:0] line,
        input logic [3:0]           boff,
        input logic [31:0]          data,
        input logic                 is_byte
    );
        logic [LINE_BITS-1:0] r;
        r = line;
        if (is_byte) begin
            r[{boff, 3'b000} +: 8] = data[7:0];
        end else begin
            r[{boff[3:2], 5'b00000} +: 32] = data;
        end
        return r;
    endfunction

    // Control state
    state_e                 state_q, state_d;
    logic [NUM_LINES-1:0]   valid_q;
    logic [NUM_LINES-1:0]   dirty_q;

    // Line array contents (no reset; valid gates their meaning)
    logic [TAG_W-1:0]       tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0]   data_q [NUM_LINES];

    // Pending store captured on a miss
    logic [31:0]            pend_addr_q;
    logic [31:0]            pend_data_q;
    logic                   pend_byte_q;

    // Drain-side lookup
    logic [IDX_W-1:0]       drn_idx;
    logic [TAG_W-1:0]       drn_tag;
    logic                   drn_hit;
    logic                   accept_hit;
    logic                   start_miss;
    logic                   fill_done;
    logic [IDX_W-1:0]       pend_idx;

    assign drn_idx    = addr_in[TAG_LO-1:4];
    assign drn_tag    = addr_in[31:TAG_LO];
    assign drn_hit    = valid_q[drn_idx] && (tag_q[drn_idx] == drn_tag);
    assign accept_hit = (state_q == ST_IDLE) && drain_in && drn_hit;
    assign start_miss = (state_q == ST_IDLE) && drain_in && !drn_hit;
    assign fill_done  = (state_q == ST_FILL) && mem_ready;
    assign pend_idx   = pend_addr_q[TAG_LO-1:4];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_miss) begin
                    // Only a valid and dirty victim needs writing back first.
                    if (valid_q[drn_idx] && dirty_q[drn_idx]) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_WB: begin
                if (mem_ready) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (mem_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // The array is frozen outside IDLE, so the victim tag/line driven during
    // WB and the pending address driven during FILL stay stable while
    // mem_req is high.
    always_comb begin
        stall_out = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                stall_out = drain_in && !drn_hit;
            end
            ST_WB: begin
                stall_out = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_q[pend_idx], pend_idx, 4'b0000};
                mem_wdata = data_q[pend_idx];
            end
            ST_FILL: begin
                // Dropping stall in the completion cycle lets the store
                // buffer advance exactly as the pending store is merged.
                stall_out = !mem_ready;
                mem_req   = 1'b1;
                mem_addr  = {pend_addr_q[31:4], 4'b0000};
            end
            default: begin
                stall_out = 1'b0;
            end
        endcase
    end

    // Valid / dirty bits
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (accept_hit) begin
                dirty_q[drn_idx] <= 1'b1;
            end
            if (fill_done) begin
                valid_q[pend_idx] <= 1'b1;
                dirty_q[pend_idx] <= 1'b1;
            end
        end
    end

    // Pending store capture; the re-presented store is never re-examined.
    always_ff @(posedge clk) begin
        if (start_miss) begin
            pend_addr_q <= addr_in;
            pend_data_q <= data_in;
            pend_byte_q <= is_byte_in;
        end
    end

    // Line data and tags
    always_ff @(posedge clk) begin
        if (accept_hit) begin
            data_q[drn_idx] <= merge_store(data_q[drn_idx], addr_in[3:0],
                                           data_in, is_byte_in);
        end
        if (fill_done) begin
            data_q[pend_idx] <= merge_store(mem_rdata, pend_addr_q[3:0],
                                            pend_data_q, pend_byte_q);
            tag_q[pend_idx]  <= pend_addr_q[31:TAG_LO];
        end
    end

    // Probe port: reads the array as it stands before this cycle's writes.
    logic [IDX_W-1:0]     lk_idx;
    logic [LINE_BITS-1:0] lk_line;
    logic                 unused_lk;

    assign lk_idx    = lk_addr[TAG_LO-1:4];
    assign lk_line   = data_q[lk_idx];
    assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_addr[31:TAG_LO]);
    assign lk_data   = lk_line[{lk_addr[3:2], 5'b00000} +: 32];
    assign unused_lk = ^lk_addr[1:0];

endmodule

// File: tb/tb_sb_drain_dcache_port.sv
module tb_sb_drain_dcache_port;

    logic         clk;
    logic         reset;
    logic         drain_in;
    logic [31:0]  addr_in;
    logic [31:0]  data_in;
    logic         is_byte_in;
    logic         stall_out;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ready;
    logic [127:0] mem_rdata;
    logic [31:0]  lk_addr;
    logic         lk_hit;
    logic [31:0]  lk_data;

    int total;
    int bad;

    sb_drain_dcache_port #(
        .NUM_LINES(4),
        .LINE_BITS(128)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .drain_in   (drain_in),
        .addr_in    (addr_in),
        .data_in    (data_in),
        .is_byte_in (is_byte_in),
        .stall_out  (stall_out),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .lk_addr    (lk_addr),
        .lk_hit     (lk_hit),
        .lk_data    (lk_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic probe(input string name, input logic [31:0] a,
                         input logic exp_hit, input logic chk_dat, input logic [31:0] exp_dat);
        lk_addr = a;
        #1;
        chk({name, "_hit"}, {127'h0, lk_hit}, {127'h0, exp_hit});
        if (chk_dat) chk({name, "_data"}, {96'h0, lk_data}, {96'h0, exp_dat});
    endtask

    task automatic drive(input logic d, input logic [31:0] a, input logic [31:0] v, input logic b);
        drain_in   = d;
        addr_in    = a;
        data_in    = v;
        is_byte_in = b;
    endtask

    typedef struct {
        logic        drain;
        logic [31:0] addr;
        logic [31:0] data;
        logic        is_byte;
        logic [31:0] lk;
        logic        exp_hit;
        logic        chk_data;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl [9];

    initial begin
        total = 0;
        bad   = 0;

        // Back-to-back hits on line 0x100; probes see pre-write contents.
        tbl[0] = '{1'b1, 32'h104, 32'h11111111, 1'b0, 32'h100,  1'b1, 1'b1, 32'hDE55BEEF};
        tbl[1] = '{1'b1, 32'h108, 32'h22222222, 1'b0, 32'h104,  1'b1, 1'b1, 32'h11111111};
        tbl[2] = '{1'b1, 32'h10C, 32'h33333333, 1'b0, 32'h108,  1'b1, 1'b1, 32'h22222222};
        tbl[3] = '{1'b1, 32'h10F, 32'h000000A5, 1'b1, 32'h10C,  1'b1, 1'b1, 32'h33333333};
        tbl[4] = '{1'b0, 32'h0,   32'h0,        1'b0, 32'h10C,  1'b1, 1'b1, 32'hA5333333};
        tbl[5] = '{1'b0, 32'h0,   32'h0,        1'b0, 32'h1000, 1'b0, 1'b0, 32'h0};
        tbl[6] = '{1'b0, 32'h0,   32'h0,        1'b0, 32'h110,  1'b0, 1'b0, 32'h0};
        tbl[7] = '{1'b1, 32'h106, 32'h44444444, 1'b0, 32'h104,  1'b1, 1'b1, 32'h11111111};
        tbl[8] = '{1'b0, 32'h0,   32'h0,        1'b0, 32'h104,  1'b1, 1'b1, 32'h44444444};

        reset     = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        mem_ready = 1'b0;
        mem_rdata = '0;
        lk_addr   = 32'h100;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_stall", {127'h0, stall_out}, 128'h0);
        chk("rst_req",   {127'h0, mem_req},   128'h0);
        chk("rst_we",    {127'h0, mem_we},    128'h0);
        chk("rst_addr",  {96'h0, mem_addr},   128'h0);
        chk("rst_wdata", mem_wdata,           128'h0);
        chk("rst_hit",   {127'h0, lk_hit},    128'h0);
        reset = 1'b0;

        // Cold miss, word store 0x100
        @(negedge clk);
        drive(1'b1, 32'h100, 32'hDEADBEEF, 1'b0);
        #1;
        chk("cold_T_stall", {127'h0, stall_out}, 128'h1);
        chk("cold_T_req",   {127'h0, mem_req},   128'h0);
        @(negedge clk);
        #1;
        chk("cold_fill_stall", {127'h0, stall_out}, 128'h1);
        chk("cold_fill_req",   {127'h0, mem_req},   128'h1);
        chk("cold_fill_we",    {127'h0, mem_we},    128'h0);
        chk("cold_fill_addr",  {96'h0, mem_addr},   {96'h0, 32'h100});
        mem_ready = 1'b1;
        mem_rdata = '0;
        #1;
        chk("cold_done_stall", {127'h0, stall_out}, 128'h0);
        @(negedge clk);
        mem_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("cold_after_req", {127'h0, mem_req}, 128'h0);
        probe("cold_line", 32'h100, 1'b1, 1'b1, 32'hDEADBEEF);

        // Byte hit 0x102
        @(negedge clk);
        drive(1'b1, 32'h102, 32'h00000055, 1'b1);
        #1;
        chk("byte_stall", {127'h0, stall_out}, 128'h0);
        chk("byte_req",   {127'h0, mem_req},   128'h0);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("byte_after_req", {127'h0, mem_req}, 128'h0);
        probe("byte_line", 32'h100, 1'b1, 1'b1, 32'hDE55BEEF);

        // Table: back-to-back hits and probes
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(tbl[i].drain, tbl[i].addr, tbl[i].data, tbl[i].is_byte);
            lk_addr = tbl[i].lk;
            #1;
            chk($sformatf("tbl%0d_stall", i), {127'h0, stall_out}, 128'h0);
            chk($sformatf("tbl%0d_req", i),   {127'h0, mem_req},   128'h0);
            chk($sformatf("tbl%0d_hit", i),   {127'h0, lk_hit},    {127'h0, tbl[i].exp_hit});
            if (tbl[i].chk_data)
                chk($sformatf("tbl%0d_data", i), {96'h0, lk_data}, {96'h0, tbl[i].exp_data});
        end

        // Dirty eviction: 0x140 maps onto dirty line 0x100
        @(negedge clk);
        drive(1'b1, 32'h140, 32'h12345678, 1'b0);
        #1;
        chk("evict_T_stall", {127'h0, stall_out}, 128'h1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mem_ready = (c == 2);
            #1;
            chk($sformatf("wb%0d_stall", c), {127'h0, stall_out}, 128'h1);
            chk($sformatf("wb%0d_req", c),   {127'h0, mem_req},   128'h1);
            chk($sformatf("wb%0d_we", c),    {127'h0, mem_we},    128'h1);
            chk($sformatf("wb%0d_addr", c),  {96'h0, mem_addr},   {96'h0, 32'h100});
            chk($sformatf("wb%0d_wdata", c), mem_wdata,
                128'hA5333333_22222222_44444444_DE55BEEF);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("evfill_req",   {127'h0, mem_req},   128'h1);
        chk("evfill_we",    {127'h0, mem_we},    128'h0);
        chk("evfill_addr",  {96'h0, mem_addr},   {96'h0, 32'h140});
        chk("evfill_stall", {127'h0, stall_out}, 128'h1);
        mem_ready = 1'b1;
        mem_rdata = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
        @(negedge clk);
        mem_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("evict_after_req", {127'h0, mem_req}, 128'h0);
        probe("ev_w0",  32'h140, 1'b1, 1'b1, 32'h12345678);
        probe("ev_w1",  32'h144, 1'b1, 1'b1, 32'hAAAA0001);
        probe("ev_old", 32'h100, 1'b0, 1'b0, 32'h0);

        // Clean miss held through a 5-cycle fill latency
        @(negedge clk);
        drive(1'b1, 32'h214, 32'hCAFEF00D, 1'b0);
        #1;
        chk("hold_T_stall", {127'h0, stall_out}, 128'h1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            mem_ready = (c == 4);
            mem_rdata = 128'h0F0F0F03_0F0F0F02_0F0F0F01_0F0F0F00;
            #1;
            chk($sformatf("hold%0d_req", c),   {127'h0, mem_req},   128'h1);
            chk($sformatf("hold%0d_we", c),    {127'h0, mem_we},    128'h0);
            chk($sformatf("hold%0d_addr", c),  {96'h0, mem_addr},   {96'h0, 32'h210});
            chk($sformatf("hold%0d_stall", c), {127'h0, stall_out}, {127'h0, (c != 4)});
        end
        @(negedge clk);
        mem_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("hold_after_req", {127'h0, mem_req}, 128'h0);
        probe("hold_w1", 32'h214, 1'b1, 1'b1, 32'hCAFEF00D);
        probe("hold_w2", 32'h218, 1'b1, 1'b1, 32'h0F0F0F02);

        // Stray mem_ready while idle
        @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = '1;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("stray_req", {127'h0, mem_req}, 128'h0);
        probe("stray_line", 32'h214, 1'b1, 1'b1, 32'hCAFEF00D);

        // Reset during FILL
        @(negedge clk);
        drive(1'b1, 32'h320, 32'h77777777, 1'b0);
        #1;
        chk("rf_T_stall", {127'h0, stall_out}, 128'h1);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("rf_fill_req",  {127'h0, mem_req}, 128'h1);
        chk("rf_fill_addr", {96'h0, mem_addr}, {96'h0, 32'h320});
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rf_req",   {127'h0, mem_req},   128'h0);
        chk("rf_stall", {127'h0, stall_out}, 128'h0);
        mem_ready = 1'b1;
        mem_rdata = 128'h55555555_55555555_55555555_55555555;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("rf_late_req", {127'h0, mem_req}, 128'h0);
        probe("rf_p320", 32'h320, 1'b0, 1'b0, 32'h0);
        probe("rf_p140", 32'h140, 1'b0, 1'b0, 32'h0);
        probe("rf_p214", 32'h214, 1'b0, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
